// File: rtl/t09_update_pkg.sv
`default_nettype none
// ============================================================================
// Module      : t09_update_pkg
// Description : State codes and mode constants for the update sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package t09_update_pkg;

    localparam logic [2:0] C_MODE_IDLE  = 3'd0;
    localparam logic [2:0] C_MODE_WAIT  = 3'd1;
    localparam logic [2:0] C_MODE_WRITE = 3'd2;
    localparam logic [2:0] C_MODE_DONE  = 3'd3;
    localparam logic [2:0] C_MODE_ERR   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = C_MODE_IDLE,
        ST_WAIT  = C_MODE_WAIT,
        ST_WRITE = C_MODE_WRITE,
        ST_DONE  = C_MODE_DONE,
        ST_ERR   = C_MODE_ERR
    } state_t;

endpackage
`default_nettype wire

// File: rtl/t09_prio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : t09_prio_arbiter
// Description : Combinational fixed-priority select, lowest index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module t09_prio_arbiter #(
    parameter int NUM_CH = 2
) (
    input  logic [NUM_CH-1:0] i_req,
    output logic [NUM_CH-1:0] o_grant
);

    // Two's-complement trick isolates the lowest set bit.
    assign o_grant = i_req & (~i_req + NUM_CH'(1));

endmodule
`default_nettype wire

// File: rtl/t09_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : t09_update_sequencer
// Description : Multi-channel command sequencer issuing write beats with
//               stall handling. Define T09_UPD_TIMEOUT_EN to enable the
//               stall timeout (ERR state, timeout_err pulse).
// Revision    : 1.0 - initial release
// ============================================================================
module t09_update_sequencer
    import t09_update_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 9,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              pause,
    input  logic              cmd_finished,
    output logic              wr,
    output logic              cmd_done,
    output logic [NUM_CH-1:0] grant,
    output logic [2:0]        mode,
    output logic              busy,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              timeout_err
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NUM_CH-1:0] r_grant;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [NUM_CH-1:0] w_arb_grant;
    logic              w_stall_hit;

    t09_prio_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_req   (req),
        .o_grant (w_arb_grant)
    );

`ifdef T09_UPD_TIMEOUT_EN
    localparam int                 STALL_W     = $clog2(TIMEOUT);
    localparam logic [STALL_W-1:0] C_STALL_MAX = STALL_W'(TIMEOUT - 1);

    logic [STALL_W-1:0] r_stall;

    // Held at zero outside WAIT so every entry to WAIT starts a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= '0;
        end else if (r_state != ST_WAIT) begin
            r_stall <= '0;
        end else if (pause && !w_stall_hit) begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end

    assign w_stall_hit = (r_stall == C_STALL_MAX);
    assign timeout_err = (r_state == ST_ERR);
`else
    assign w_stall_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!pause) begin
                    w_state_nxt = ST_WRITE;
                end else if (w_stall_hit) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_WRITE: begin
                w_state_nxt = cmd_finished ? ST_DONE : ST_WAIT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant is only loaded from IDLE, so req changes mid-command are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant    <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_grant    <= w_arb_grant;
                        r_beat_cnt <= '0;
                    end
                end
                ST_WRITE: begin
                    if (r_beat_cnt != {CNT_W{1'b1}}) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_grant <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign wr       = (r_state == ST_WRITE);
    assign cmd_done = (r_state == ST_DONE);
    assign busy     = (r_state != ST_IDLE);
    assign mode     = r_state;
    assign grant    = r_grant;
    assign beat_cnt = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_t09_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_t09_update_sequencer
// Description : Self-checking bench; two instances share stimulus, one with a
//               2-bit beat counter to observe saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t09_update_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic       pause = 1'b0;
    logic       cmd_finished = 1'b0;

    logic       wr, cmd_done, busy, timeout_err;
    logic [1:0] grant;
    logic [2:0] mode;
    logic [8:0] beat_cnt;

    logic       s_wr, s_cmd_done, s_busy, s_timeout_err;
    logic [1:0] s_grant;
    logic [2:0] s_mode;
    logic [1:0] s_beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int terr_cnt = 0;

    t09_update_sequencer #(.NUM_CH(2), .CNT_W(9), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .req(req), .pause(pause),
        .cmd_finished(cmd_finished), .wr(wr), .cmd_done(cmd_done),
        .grant(grant), .mode(mode), .busy(busy), .beat_cnt(beat_cnt),
        .timeout_err(timeout_err)
    );

    t09_update_sequencer #(.NUM_CH(2), .CNT_W(2), .TIMEOUT(4)) dut_sat (
        .clk(clk), .rst(rst), .req(req), .pause(pause),
        .cmd_finished(cmd_finished), .wr(s_wr), .cmd_done(s_cmd_done),
        .grant(s_grant), .mode(s_mode), .busy(s_busy), .beat_cnt(s_beat_cnt),
        .timeout_err(s_timeout_err)
    );

    always #5 clk = ~clk;

    // Pulse counters and the one-hot-pulse rule, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr === 1'b1)          wr_cnt++;
            if (cmd_done === 1'b1)    done_cnt++;
            if (timeout_err === 1'b1) terr_cnt++;
            n_checks++;
            if (((wr & cmd_done) | (wr & timeout_err) | (cmd_done & timeout_err)) !== 1'b0) begin
                n_fail++;
                $display("FAIL pulse_exclusive: wr=%b cmd_done=%b timeout_err=%b", wr, cmd_done, timeout_err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [1:0] ref_grant(input logic [1:0] r);
        for (int i = 0; i < 2; i++) begin
            if (r[i]) return 2'(1 << i);
        end
        return 2'b00;
    endfunction

    function automatic int ref_sat(input int n, input int max_val);
        return (n > max_val) ? max_val : n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full command: p0 pause cycles before beat 0 (-1 = random), random
    // pauses up to pmax elsewhere; req switches to mid_req once granted.
    task automatic run_cmd(input logic [1:0] pat, input int n, input int p0,
                           input int pmax, input logic [1:0] mid_req,
                           input logic [1:0] end_req);
        logic [1:0] eg;
        int w0, d0, p;
        eg = ref_grant(pat);
        w0 = wr_cnt;
        d0 = done_cnt;
        req = pat; pause = 1'b0; cmd_finished = 1'b0;
        step();
        n_checks++;
        if (mode !== 3'd1 || grant !== eg) begin
            n_fail++;
            $display("FAIL grant_reg: mode=%0d grant=%b want mode=1 grant=%b", mode, grant, eg);
        end
        req = mid_req;
        for (int b = 0; b < n; b++) begin
            p = (b == 0 && p0 >= 0) ? p0 : int'($urandom_range(0, pmax));
            repeat (p) begin
                pause = 1'b1;
                cmd_finished = 1'($urandom);
                step();
                n_checks++;
                if (mode !== 3'd1 || wr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wait_hold: mode=%0d wr=%b want mode=1 wr=0", mode, wr);
                end
            end
            pause = 1'b0;
            cmd_finished = 1'b0;
            step();
            n_checks++;
            if (wr !== 1'b1 || mode !== 3'd2 || grant !== eg) begin
                n_fail++;
                $display("FAIL write_beat: wr=%b mode=%0d grant=%b want wr=1 mode=2 grant=%b", wr, mode, grant, eg);
            end
            cmd_finished = (b == n - 1);
            pause = 1'($urandom);
            step();
        end
        n_checks++;
        if (cmd_done !== 1'b1 || mode !== 3'd3 || grant !== eg) begin
            n_fail++;
            $display("FAIL done_pulse: cmd_done=%b mode=%0d grant=%b want 1/3/%b", cmd_done, mode, grant, eg);
        end
        n_checks++;
        if (beat_cnt !== 9'(ref_sat(n, 511)) || s_beat_cnt !== 2'(ref_sat(n, 3))) begin
            n_fail++;
            $display("FAIL beat_cnt: got %0d/%0d want %0d/%0d", beat_cnt, s_beat_cnt, ref_sat(n, 511), ref_sat(n, 3));
        end
        cmd_finished = 1'b0;
        pause = 1'b0;
        req = end_req;
        step();
        n_checks++;
        if (busy !== 1'b0 || grant !== 2'b00 || cmd_done !== 1'b0 || mode !== 3'd0) begin
            n_fail++;
            $display("FAIL back_idle: busy=%b grant=%b cmd_done=%b mode=%0d want 0/00/0/0", busy, grant, cmd_done, mode);
        end
        n_checks++;
        if (wr_cnt - w0 != n || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL pulse_count: wr=%0d done=%0d want wr=%0d done=1", wr_cnt - w0, done_cnt - d0, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 2'b01;
        step();
        step();
        n_checks++;
        if ({wr, cmd_done, timeout_err, busy, mode, grant} !== 9'd0 || beat_cnt !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_state: wr=%b done=%b terr=%b busy=%b mode=%0d grant=%b beat=%0d want all 0",
                     wr, cmd_done, timeout_err, busy, mode, grant, beat_cnt);
        end
        rst = 1'b0;
        // The very next edge must already take the pending request.
        run_cmd(2'b01, 1, 0, 0, 2'b01, 2'b00);
    endtask

    task automatic test_latency();
        run_cmd(2'b11, 1, 0, 0, 2'b11, 2'b00);
    endtask

    task automatic test_pause();
        run_cmd(2'b10, 3, 3, 0, 2'b10, 2'b00);
    endtask

    task automatic test_timeout();
        int t0, d0;
        t0 = terr_cnt;
        d0 = done_cnt;
        req = 2'b10;
        step();
        req = 2'b00;
        pause = 1'b1;
`ifdef T09_UPD_TIMEOUT_EN
        repeat (3) begin
            step();
            n_checks++;
            if (mode !== 3'd1 || timeout_err !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait: mode=%0d terr=%b want mode=1 terr=0", mode, timeout_err);
            end
        end
        step();
        n_checks++;
        if (mode !== 3'd4 || timeout_err !== 1'b1 || cmd_done !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err: mode=%0d terr=%b done=%b want 4/1/0", mode, timeout_err, cmd_done);
        end
        pause = 1'b0;
        step();
        n_checks++;
        if (mode !== 3'd0 || grant !== 2'b00 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_idle: mode=%0d grant=%b terr=%b want 0/00/0", mode, grant, timeout_err);
        end
        n_checks++;
        if (terr_cnt - t0 != 1 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL timeout_pulses: terr=%0d done=%0d want terr=1 done=0", terr_cnt - t0, done_cnt - d0);
        end
`else
        repeat (20) begin
            step();
            n_checks++;
            if (mode !== 3'd1 || timeout_err !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_forever: mode=%0d terr=%b want mode=1 terr=0", mode, timeout_err);
            end
        end
        pause = 1'b0;
        step();
        cmd_finished = 1'b1;
        step();
        cmd_finished = 1'b0;
        step();
        n_checks++;
        if (mode !== 3'd0 || terr_cnt != t0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL stall_release: mode=%0d terr=%0d done=%0d want 0/0/1", mode, terr_cnt - t0, done_cnt - d0);
        end
`endif
    endtask

    task automatic test_reset_mid_write();
        int d0;
        req = 2'b01;
        pause = 1'b0;
        step();
        step();
        n_checks++;
        if (wr !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_write: wr=%b want 1", wr);
        end
        d0 = done_cnt;
        cmd_finished = 1'b1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({wr, cmd_done, timeout_err, busy, mode, grant} !== 9'd0 || beat_cnt !== 9'd0 ||
            {s_wr, s_busy, s_mode, s_grant, s_beat_cnt} !== 9'd0) begin
            n_fail++;
            $display("FAIL async_reset: wr=%b done=%b busy=%b mode=%0d grant=%b beat=%0d want all 0",
                     wr, cmd_done, busy, mode, grant, beat_cnt);
        end
        step();
        rst = 1'b0;
        cmd_finished = 1'b0;
        req = 2'b00;
        step();
        step();
        n_checks++;
        if (mode !== 3'd0 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL reset_abandon: mode=%0d extra_done=%0d want 0/0", mode, done_cnt - d0);
        end
    endtask

    task automatic test_saturate();
        run_cmd(2'b01, 5, 0, 1, 2'b00, 2'b00);
    endtask

    task automatic test_back_to_back();
        run_cmd(2'b01, 2, 0, 1, 2'b10, 2'b10);
        run_cmd(2'b10, 1, 0, 0, 2'b00, 2'b00);
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            run_cmd(2'($urandom_range(1, 3)), int'($urandom_range(1, 6)), -1, 3,
                    2'($urandom_range(0, 3)), 2'b00);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_pause();
        test_timeout();
        test_reset_mid_write();
        test_saturate();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/t09_update_sequencer.md
T09_UPDATE_SEQUENCER -- requirements
Module: t09_update_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of request channels (channel 0 = init, channel 1 = update), legal range 1..8.
REQ-002 SHALL have parameter CNT_W, default 9: width of the write-beat counter.
REQ-003 SHALL have parameter TIMEOUT, default 256: maximum consecutive paused cycles in WAIT, legal range 2..2^16.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req, input, NUM_CH: per-channel command request, level-sensitive.
REQ-007 SHALL have port pause, input, 1: downstream stall; holds the sequencer in WAIT.
REQ-008 SHALL have port cmd_finished, input, 1: sampled in WRITE only; marks the last beat of the command.
REQ-009 SHALL have port wr, output, 1: one-cycle write strobe per beat.
REQ-010 SHALL have port cmd_done, output, 1: one-cycle pulse on command completion.
REQ-011 SHALL have port grant, output, NUM_CH: one-hot active channel, all-zero when idle.
REQ-012 SHALL have port mode, output, 3: current state encoding.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port beat_cnt, output, CNT_W: number of wr beats issued in the current command.
REQ-015 SHALL have port timeout_err, output, 1: one-cycle pulse on stall timeout.

Function
REQ-016 SHALL implement the states IDLE=0, WAIT=1, WRITE=2, DONE=3 and ERR=4, with mode equal to the state code.
REQ-017 In IDLE with any req bit high, SHALL register grant to the lowest-index asserted channel, clear beat_cnt and move to WAIT on the next edge.
REQ-018 In IDLE with req all-zero, SHALL remain in IDLE with grant at zero.
REQ-019 WAIT: if pause=1, SHALL stay in WAIT; if pause=0, SHALL move to WRITE.
REQ-020 WRITE: SHALL assert wr=1 combinationally for exactly that cycle.
REQ-021 WRITE: SHALL increment beat_cnt, saturating at all-ones.
REQ-022 WRITE: if cmd_finished=1, SHALL move to DONE; otherwise SHALL move back to WAIT.
REQ-023 DONE: SHALL assert cmd_done=1 for one cycle, clear grant and move to IDLE.
REQ-024 SHALL ignore req changes while busy: grant is held, a new request waits for IDLE, and dropping the granted req mid-command does not abort the command.
REQ-025 Minimum latency SHALL be: req rising in IDLE, then wr two cycles later, then cmd_done one cycle after the last wr.
REQ-026 SHALL reset the stall counter on every entry to WAIT and increment it on each paused WAIT cycle.
REQ-027 When the stall counter reaches TIMEOUT-1 with pause still 1, SHALL move to ERR.
REQ-028 ERR: SHALL pulse timeout_err, clear grant and move to IDLE, without pulsing cmd_done.
REQ-029 SHALL keep wr, cmd_done and timeout_err mutually exclusive in every cycle.

Reset
REQ-030 On rst=1, SHALL immediately force state IDLE and set grant=0, beat_cnt=0, stall counter=0, wr=0, cmd_done=0, timeout_err=0, busy=0 and mode=0.
REQ-031 When rst is asserted mid-command, SHALL abandon the command without emitting cmd_done.
REQ-032 SHALL sample the first req on the first rising edge after rst deasserts.

Configuration
REQ-033 With T09_UPD_TIMEOUT_EN defined, SHALL include the stall counter, the ERR state and timeout_err per REQ-026..028.
REQ-034 Without T09_UPD_TIMEOUT_EN, SHALL have no stall counter, SHALL make ERR unreachable (decoding it to IDLE), SHALL tie timeout_err to 0, and WAIT SHALL stall indefinitely.

Structure
REQ-035 Package t09_update_pkg SHALL hold the state typedef (3-bit codes 0..4) and the mode constants.
REQ-036 The grant logic SHALL be the sub-module t09_prio_arbiter: combinational lowest-index one-hot select, parametrised by NUM_CH, with grant registered in the parent.

Verification
REQ-037 Bench SHALL cover: NUM_CH=2, req=2'b11 in IDLE, pause=0, cmd_finished=1 on the first WRITE -> grant=2'b01, wr high at cycle +2, cmd_done at +3, beat_cnt=1.
REQ-038 Bench SHALL cover: req=2'b10, pause high 3 cycles in WAIT, cmd_finished on the third WRITE -> exactly 3 wr pulses, beat_cnt=3, grant=2'b10 throughout.
REQ-039 Bench SHALL cover: with T09_UPD_TIMEOUT_EN and TIMEOUT=4, pause held high -> ERR after 4 WAIT cycles, timeout_err single pulse, no cmd_done, then IDLE.
REQ-040 Bench SHALL cover: rst pulsed while in WRITE -> all outputs 0 within the same cycle, no cmd_done.
REQ-041 Bench SHALL cover: CNT_W=2 with 5 beats -> beat_cnt saturates at 3.
REQ-042 Bench SHALL cover: req[0] dropped and req[1] raised mid-command -> the current command completes, then channel 1 is granted from IDLE.
